// File: rtl/simon_sequence_ctrl.sv
// rtl/simon_sequence_ctrl.sv - Simon game sequencer: grows, plays back and checks a move sequence
// Optional input timeout built when SIMON_INPUT_TIMEOUT_EN is defined.
module simon_sequence_ctrl #(
  parameter int MAX_LEN        = 8,
  parameter int ON_CYCLES      = 12500000,
  parameter int GAP_CYCLES     = 6250000,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] btn,
  output logic [7:0] led,
  output logic [4:0] level,
  output logic       busy,
  output logic       win,
  output logic       lose
);

  localparam int MAXC0 = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int MAXC  = (TIMEOUT_CYCLES > MAXC0) ? TIMEOUT_CYCLES : MAXC0;
  localparam int CW    = $clog2(MAXC + 1);
  localparam int IW    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [CW-1:0] ON_L  = CW'(ON_CYCLES);
  localparam logic [CW-1:0] GAP_L = CW'(GAP_CYCLES);
`ifdef SIMON_INPUT_TIMEOUT_EN
  localparam logic [CW-1:0] IN_L  = CW'(TIMEOUT_CYCLES);
`else
  localparam logic [CW-1:0] IN_L  = '0;
`endif

  typedef enum logic [2:0] {
    IDLE, ADD, GAP0, SHOW_ON, SHOW_GAP, INPUT, WIN, LOSE
  } state_t;

  state_t        state, state_nx;
  logic [4:0]    level_nx, idx, idx_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [7:0]    lfsr, led_nx;
  logic [1:0]    mem [MAX_LEN];
  logic [1:0]    cur_move;
  logic [3:0]    want;
  logic          cnt_done;

  function automatic logic [7:0] move_led(input logic [1:0] m);
    return 8'h03 << {m, 1'b0};
  endfunction

  assign cur_move = mem[idx[IW-1:0]];
  assign want     = 4'b0001 << cur_move;
  assign cnt_done = (cnt == CW'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      level <= '0;
      idx   <= '0;
      cnt   <= '0;
      led   <= 8'h00;
      lfsr  <= 8'hA5;
    end else begin
      state <= state_nx;
      level <= level_nx;
      idx   <= idx_nx;
      cnt   <= cnt_nx;
      led   <= led_nx;
      // Galois form of x^8+x^6+x^5+x^4+1, free-running so move choice depends on player timing
      lfsr  <= {1'b0, lfsr[7:1]} ^ ({8{lfsr[0]}} & 8'hB8);
      if (state == ADD) mem[level[IW-1:0]] <= lfsr[1:0];
    end
  end

  always_comb begin
    state_nx = state;
    level_nx = level;
    idx_nx   = idx;
    cnt_nx   = (cnt != '0) ? cnt - CW'(1) : cnt;
    case (state)
      IDLE: if (start) state_nx = ADD;
      ADD: begin
        level_nx = level + 5'd1;
        idx_nx   = '0;
        cnt_nx   = GAP_L;
        state_nx = GAP0;
      end
      GAP0: if (cnt_done) begin
        state_nx = SHOW_ON;
        cnt_nx   = ON_L;
      end
      SHOW_ON: if (cnt_done) begin
        state_nx = SHOW_GAP;
        cnt_nx   = GAP_L;
      end
      SHOW_GAP: if (cnt_done) begin
        if (idx + 5'd1 == level) begin
          state_nx = INPUT;
          idx_nx   = '0;
          cnt_nx   = IN_L;
        end else begin
          state_nx = SHOW_ON;
          idx_nx   = idx + 5'd1;
          cnt_nx   = ON_L;
        end
      end
      INPUT: begin
        // A press always wins over start and over an expiring timeout
        if (btn != 4'b0000) begin
          if (btn == want) begin
            idx_nx = idx + 5'd1;
            cnt_nx = IN_L;
            if (idx + 5'd1 == level)
              state_nx = (level == 5'(MAX_LEN)) ? WIN : ADD;
          end else begin
            state_nx = LOSE;
          end
        end
`ifdef SIMON_INPUT_TIMEOUT_EN
        else if (cnt_done) state_nx = LOSE;
`endif
      end
      WIN, LOSE: if (start) begin
        state_nx = ADD;
        level_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = !(state == IDLE || state == WIN || state == LOSE);
    win  = (state == WIN);
    lose = (state == LOSE);
    // led is registered off the next state so it switches on the same edge as the state
    case (state_nx)
      SHOW_ON: led_nx = move_led(mem[idx_nx[IW-1:0]]);
      WIN:     led_nx = 8'hFF;
      LOSE:    led_nx = 8'hAA;
      default: led_nx = 8'h00;
    endcase
  end

endmodule
